// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data Wishbone port arbiter.
// The FSM encoding, the grant-port encodings and the stall-counter width helper live here.
package processorci_wb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  localparam logic GRANT_PORT_I = 1'b0;
  localparam logic GRANT_PORT_D = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // A zero timeout still needs a one-bit counter so the port stays legal.
  function automatic int stall_cnt_width(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating stall counter for the arbiter.
// It flags expiry when the count reaches TIMEOUT_CYCLES; a zero TIMEOUT_CYCLES never expires.
module wb_timeout_counter
  import processorci_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CW = stall_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES) : {CW{1'b1}};

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (run && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (TIMEOUT_CYCLES > 0) && (count == LIMIT);

endmodule

// File: rtl/wb_port_arbiter.sv
// Two-master Wishbone arbiter: instruction (read-only) and data ports share one slave bus.
// Round-robin on ties, grant held for the whole cycle, optional stall timeout that fakes an ack.
module wb_port_arbiter
  import processorci_wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // instruction port
  input  logic                    i_cyc_i,
  input  logic                    i_stb_i,
  input  logic [ADDR_WIDTH-1:0]   i_adr_i,
  output logic [DATA_WIDTH-1:0]   i_dat_o,
  output logic                    i_ack_o,
  // data port
  input  logic                    d_cyc_i,
  input  logic                    d_stb_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_sel_i,
  input  logic [ADDR_WIDTH-1:0]   d_adr_i,
  input  logic [DATA_WIDTH-1:0]   d_dat_i,
  output logic [DATA_WIDTH-1:0]   d_dat_o,
  output logic                    d_ack_o,
  // shared slave bus
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  output logic                    timeout_o
);

  arb_state_t state;
  logic       last_grant;
  logic       i_req, d_req;
  logic       in_grant, port_stb;
  logic       stall_run, stall_clear, stall_expired;
  logic       timeout_fire, bus_ack, port_ack;

  assign i_req = i_cyc_i & i_stb_i;
  assign d_req = d_cyc_i & d_stb_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GRANT_PORT_D;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_req && (!d_req || (last_grant == GRANT_PORT_D))) begin
            state      <= GRANT_I;
            last_grant <= GRANT_PORT_I;
          end else if (d_req) begin
            state      <= GRANT_D;
            last_grant <= GRANT_PORT_D;
          end
        end
        GRANT_I: if (!i_cyc_i) state <= IDLE;
        GRANT_D: if (!d_cyc_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_grant = (state != IDLE);
  assign port_stb = (state == GRANT_I) ? i_stb_i :
                    (state == GRANT_D) ? d_stb_i : 1'b0;

  // A real ack in the expiry cycle wins, so the strobe is only gated when the slave is silent.
  assign timeout_fire = port_stb & stall_expired & ~s_ack_i;
  assign s_stb_o      = port_stb & ~timeout_fire;
  assign bus_ack      = s_ack_i & s_stb_o;
  assign port_ack     = bus_ack | timeout_fire;
  assign timeout_o    = timeout_fire;

  assign stall_run   = s_stb_o & ~s_ack_i;
  assign stall_clear = ~in_grant | ~s_stb_o | s_ack_i;

  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_stall (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (stall_run),
    .clear  (stall_clear),
    .expired(stall_expired)
  );

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    s_cyc_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    i_ack_o = 1'b0;
    i_dat_o = '0;
    d_ack_o = 1'b0;
    d_dat_o = '0;
    case (state)
      GRANT_I: begin
        s_cyc_o = i_cyc_i;
        s_sel_o = '1;
        s_adr_o = i_adr_i;
        i_ack_o = port_ack;
        i_dat_o = timeout_fire ? '0 : s_dat_i;
      end
      GRANT_D: begin
        s_cyc_o = d_cyc_i;
        s_we_o  = d_we_i;
        s_sel_o = d_sel_i;
        s_adr_o = d_adr_i;
        s_dat_o = d_dat_i;
        d_ack_o = port_ack;
        d_dat_o = timeout_fire ? '0 : s_dat_i;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of all address buses.
REQ-002 Parameter DATA_WIDTH, default 32, width of all data buses; the sel width SHALL be DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, number of stall cycles before a synthesized ack; 0 SHALL disable the timeout.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 i_cyc_i, i_stb_i  input  1 each  instruction-port (read-only master) cycle and strobe.
REQ-007 i_adr_i  input  ADDR_WIDTH  instruction-port address.
REQ-008 i_dat_o  output  DATA_WIDTH; i_ack_o  output  1  instruction-port read data and ack.
REQ-009 d_cyc_i, d_stb_i, d_we_i  input  1 each  data-port cycle, strobe and write enable.
REQ-010 d_sel_i  input  DATA_WIDTH/8; d_adr_i  input  ADDR_WIDTH; d_dat_i  input  DATA_WIDTH  data-port byte select, address and write data.
REQ-011 d_dat_o  output  DATA_WIDTH; d_ack_o  output  1  data-port read data and ack.
REQ-012 s_cyc_o, s_stb_o, s_we_o  output  1 each; s_sel_o  output  DATA_WIDTH/8; s_adr_o  output  ADDR_WIDTH; s_dat_o  output  DATA_WIDTH  shared memory-bus master side.
REQ-013 s_dat_i  input  DATA_WIDTH; s_ack_i  input  1  shared memory-bus read data and ack.
REQ-014 timeout_o  output  1  one-cycle pulse on a synthesized ack.

Function
REQ-015 The FSM SHALL have the states IDLE, GRANT_I and GRANT_D.
REQ-016 In IDLE, all s_* outputs and both acks SHALL be 0.
REQ-017 IDLE SHALL move to GRANT_I or GRANT_D on the next edge when the corresponding cyc_i&stb_i is high.
REQ-018 Arbitration latency SHALL be one cycle: a request seen in IDLE at cycle N drives s_cyc_o/s_stb_o at N+1.
REQ-019 On simultaneous requests, a round-robin last_grant bit SHALL select the port not granted last; last_grant SHALL update on every grant.
REQ-020 In GRANT_x, the s_* outputs SHALL be driven combinationally from port x; s_we_o SHALL be 0 in GRANT_I; s_sel_o SHALL be all-ones in GRANT_I; s_dat_o SHALL be 0 in GRANT_I.
REQ-021 s_ack_i SHALL route combinationally to the granted port's ack; the non-granted ack SHALL be 0.
REQ-022 s_dat_i SHALL route to the granted port's dat_o; the non-granted dat_o SHALL be 0.
REQ-023 The grant SHALL be held while the granted port's cyc_i is high, including across multiple strobes.
REQ-024 When the granted cyc_i is sampled low, the FSM SHALL return to IDLE on the next edge, giving one idle bubble before any regrant.
REQ-025 An s_ack_i received in IDLE, or with s_stb_o low, SHALL be ignored.
REQ-026 A stall counter SHALL increment each cycle that s_stb_o=1 and s_ack_i=0, and SHALL clear on ack, on stb low, and on leaving GRANT.
REQ-027 When the stall count reaches TIMEOUT_CYCLES (nonzero), for exactly one cycle: the granted ack SHALL be 1, the granted dat_o SHALL be 0, s_stb_o SHALL be 0, and timeout_o SHALL be 1; the counter SHALL then clear.
REQ-028 The counter width SHALL be $clog2(TIMEOUT_CYCLES+1) and it SHALL saturate with no wrap-around.
REQ-029 If s_ack_i arrives in the same cycle as the timeout, the real ack SHALL win: s_dat_i is passed through and timeout_o stays 0.

Reset
REQ-030 With rst_n low at an edge: state SHALL be IDLE, last_grant SHALL be D (so I wins the first tie), the counter SHALL be 0, and all outputs SHALL be 0 the following cycle.
REQ-031 Reset mid-transaction SHALL abandon the transfer with no ack issued; a late s_ack_i SHALL be ignored per REQ-025.

Structure
REQ-032 Package processorci_wb_pkg SHALL hold the arb_state_t enum, the grant encodings GRANT_PORT_I=0 and GRANT_PORT_D=1, and the default timeout constant.
REQ-033 The stall counter SHALL be the sub-module wb_timeout_counter, parameterized by TIMEOUT_CYCLES, with inputs clk, rst_n, run, clear and output expired.
REQ-034 The RTL SHALL contain no combinational loop from s_ack_i to s_stb_o other than the timeout gating.

Verification
REQ-035 Single I read: i_adr_i=0x100, slave acks 2 cycles after stb with 0x00000013 -> s_adr_o=0x100, i_dat_o=0x13, i_ack_o=1 for one cycle, d_ack_o=0.
REQ-036 D write: d_adr_i=0x2000, sel=0b0011, dat=0xCAFEBABE -> s_we_o=1, s_sel_o=0b0011, s_dat_o=0xCAFEBABE, d_ack_o on slave ack.
REQ-037 Simultaneous requests for 4 consecutive rounds out of reset -> grant order I, D, I, D, each grant separated by one IDLE cycle.
REQ-038 TIMEOUT_CYCLES=8, slave never acks -> at stall cycle 8 d_ack_o=1, d_dat_o=0, timeout_o=1 for exactly one cycle; with TIMEOUT_CYCLES=0 the bus hangs indefinitely.
REQ-039 Ack in the same cycle as timeout expiry -> data passed through, timeout_o=0.
REQ-040 rst_n low while GRANT_D is waiting, then slave acks -> no d_ack_o, all outputs 0, next I request granted first.
